// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared FSM encodings, parity modes and width helper for the UART stages
// Contents:
//   state_e   3-bit transmit FSM state encoding
//   PAR_*     parity mode values for the PARITY parameter
//   clog2     ceiling log2, used for counter widths (also meant for the RX stage)
package fifo_uart_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_PAR   = 3'd5,
    ST_STOP  = 3'd6
  } state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port plus serial line and status of the UART transmit stage
// Signals:
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid the cycle after a read pulse
//   fifo_rd_en    single-cycle read pulse to the FIFO
//   tx            serial line, idle high
//   busy          frame in progress (FETCH through last stop-bit cycle)
//   tx_done       pulse on the final cycle of the last stop bit
// Modports: master = transmit stage, slave = FIFO/pad side.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;
  logic             tx_done;
  modport master (
    input  fifo_empty, fifo_rd_data,
    output fifo_rd_en, tx, busy, tx_done
  );
  modport slave (
    output fifo_empty, fifo_rd_data,
    input  fifo_rd_en, tx, busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// fifo_uart_tx_baud_tick: bit-time counter with one-cycle tick on terminal count
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   clear  holds the counter at 0 (no tick while asserted)
//   tick   high on the last cycle of each CLKS_PER_BIT period
module fifo_uart_tx_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt;
  assign tick = !clear && cnt == LAST;
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the FIFO one byte per frame and sends it as a UART frame on tx
// Parameters:
//   WIDTH         data bits per frame (matches FIFO width)
//   CLKS_PER_BIT  clock cycles per bit time, >= 2
//   PARITY        PAR_NONE / PAR_ODD / PAR_EVEN
//   STOP_BITS     1 or 2
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  master side of fifo_uart_tx_if (FIFO read port, tx, busy, tx_done)
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input logic          clk,
  input logic          rst,
  fifo_uart_tx_if.master bus
);
  localparam int BW = clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam state_e AFTER_DATA = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
  state_e           state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             par, par_n;
  logic             tx_q, tx_n;
  logic             tick, clear;
  // the bit timer only runs while a frame is on the line
  assign clear = state == ST_IDLE || state == ST_FETCH || state == ST_LOAD;
  fifo_uart_tx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    case (state)
      ST_IDLE:  state_n = bus.fifo_empty ? ST_IDLE : ST_FETCH;
      ST_FETCH: state_n = ST_LOAD;
      ST_LOAD: begin
        state_n   = ST_START;
        shift_n   = bus.fifo_rd_data;
        par_n     = ^bus.fifo_rd_data ^ (PARITY == PAR_ODD);
        bit_cnt_n = '0;
      end
      ST_START: state_n = tick ? ST_DATA : ST_START;
      ST_DATA: if (tick) begin
        shift_n   = shift >> 1;
        bit_cnt_n = bit_cnt == LAST_DATA ? '0 : bit_cnt + BW'(1);
        state_n   = bit_cnt == LAST_DATA ? AFTER_DATA : ST_DATA;
      end
      ST_PAR:   state_n = tick ? ST_STOP : ST_PAR;
      ST_STOP: if (tick) begin
        bit_cnt_n = bit_cnt == LAST_STOP ? '0 : bit_cnt + BW'(1);
        state_n   = bit_cnt == LAST_STOP ? ST_IDLE : ST_STOP;
      end
      default:  state_n = ST_IDLE;
    endcase
    // tx is registered, so it is decoded from the next state and next shift value
    tx_n = state_n == ST_START ? 1'b0 :
           state_n == ST_DATA  ? shift_n[0] :
           state_n == ST_PAR   ? par_n : 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      par     <= par_n;
      tx_q    <= tx_n;
    end
  assign bus.tx         = tx_q;
  assign bus.fifo_rd_en = state == ST_FETCH;
  assign bus.busy       = state != ST_IDLE;
  assign bus.tx_done    = state == ST_STOP && tick && bit_cnt == LAST_STOP;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx across four parameter sets sharing one FIFO model
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;
  localparam int CPB [4] = '{4, 4, 4, 2};
  localparam int PAR [4] = '{0, 2, 1, 0};
  localparam int STB [4] = '{1, 1, 1, 2};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [7:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  int rd_cnt = 0;
  logic [7:0] rd_data = 8'h00;
  logic [3:0] tx, rd_en, busy, done;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  // only the selected instance sees a non-empty FIFO
  always @(posedge clk) begin
    if (|rd_en) rd_cnt <= rd_cnt + 1;
    if (rd_en[sel]) begin
      rd_data <= mem[rp[5:0]];
      rp <= rp + 1;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : gen
    fifo_uart_tx_if #(.WIDTH(8)) bus ();
    assign bus.fifo_empty   = (sel != 2'(i)) || (wp == rp);
    assign bus.fifo_rd_data = rd_data;
    assign tx[i]    = bus.tx;
    assign rd_en[i] = bus.fifo_rd_en;
    assign busy[i]  = bus.busy;
    assign done[i]  = bus.tx_done;
    fifo_uart_tx #(
      .WIDTH(8), .CLKS_PER_BIT(CPB[i]), .PARITY(PAR[i]), .STOP_BITS(STB[i])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end
  logic tx_s, rd_s, busy_s, done_s, empty_s;
  assign tx_s    = tx[sel];
  assign rd_s    = rd_en[sel];
  assign busy_s  = busy[sel];
  assign done_s  = done[sel];
  assign empty_s = wp == rp;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    mem[wp[5:0]] = b;
    wp++;
  endtask
  // from the current negedge, wait for the start bit; also locate the read pulse and busy-low cycles
  task automatic start_wait(input string tag, input int exp_gap);
    int g = 0;
    int rd_at = -1;
    int busy_lo = 0;
    while (tx_s !== 1'b0 && g < 40) begin
      @(negedge clk);
      g++;
      if (rd_s && rd_at < 0) rd_at = g;
      if (!busy_s) busy_lo++;
    end
    check({tag, "_gap"}, g, exp_gap);
    check({tag, "_rd_at"}, rd_at, exp_gap - 2);
    check({tag, "_busy_lo"}, busy_lo, exp_gap - 3);
  endtask
  // called at the negedge of frame cycle 0; returns at the negedge of the last frame cycle
  task automatic frame(input string tag, input string bits, input int cpb);
    int n = bits.len();
    logic [31:0] obs = '0;
    logic [31:0] exp = '0;
    int bad = 0;
    int dcnt = 0;
    int dpos = -1;
    for (int b = 0; b < n; b++) begin
      exp[b] = bits[b] == "1";
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == cpb / 2) obs[b] = tx_s;
        if (tx_s !== exp[b] || busy_s !== 1'b1 || rd_s !== 1'b0) bad++;
        if (done_s) begin
          dcnt++;
          dpos = b * cpb + c;
        end
      end
    end
    check({tag, "_bits"}, obs, exp);
    check({tag, "_cycles_bad"}, bad, 0);
    check({tag, "_done_cnt"}, dcnt, 1);
    check({tag, "_done_pos"}, dpos, n * cpb - 1);
  endtask
  initial begin
    int r0;
    int bad;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 4'hF);
    check("rst_rd_en", rd_en, 4'h0);
    check("rst_busy", busy, 4'h0);
    check("rst_done", done, 4'h0);
    check("rst_state", gen[0].u_dut.state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);
    // single byte, no parity
    sel = 2'd0;
    r0 = rd_cnt;
    push(8'hA5);
    start_wait("a5", 3);
    frame("a5", "0101001011", 4);
    @(negedge clk);
    check("a5_busy_after", busy_s, 0);
    check("a5_tx_after", tx_s, 1);
    check("a5_reads", rd_cnt - r0, 1);
    repeat (3) @(negedge clk);
    // parity
    sel = 2'd1;
    push(8'hA5);
    start_wait("a5_even", 3);
    frame("a5_even", "01010010101", 4);
    repeat (3) @(negedge clk);
    push(8'h01);
    start_wait("01_even", 3);
    frame("01_even", "01000000011", 4);
    repeat (3) @(negedge clk);
    sel = 2'd2;
    push(8'hA5);
    start_wait("a5_odd", 3);
    frame("a5_odd", "01010010111", 4);
    repeat (3) @(negedge clk);
    // burst of three
    sel = 2'd0;
    r0 = rd_cnt;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    start_wait("b0", 3);
    frame("b0", "0000000001", 4);
    start_wait("b1", 4);
    frame("b1", "0111111111", 4);
    start_wait("b2", 4);
    frame("b2", "0001111001", 4);
    repeat (20) @(negedge clk);
    check("b_reads", rd_cnt - r0, 3);
    check("b_empty", empty_s, 1);
    check("b_busy", busy_s, 0);
    // empty FIFO
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 4'hF || rd_en !== 4'h0 || busy !== 4'h0) bad++;
    end
    check("empty_bad", bad, 0);
    // reset during data bit 3 of 0x5A, then 0xC3 must go out intact
    r0 = rd_cnt;
    push(8'h5A);
    push(8'hC3);
    start_wait("r5a", 3);
    repeat (4 * 4 + 1) @(negedge clk);
    check("r5a_midframe_busy", busy_s, 1);
    rst = 1'b1;
    @(negedge clk);
    check("r_tx", tx_s, 1);
    check("r_busy", busy_s, 0);
    check("r_rd_en", rd_s, 0);
    check("r_state", gen[0].u_dut.state, ST_IDLE);
    rst = 1'b0;
    start_wait("rc3", 3);
    frame("rc3", "0110000111", 4);
    check("r_reads", rd_cnt - r0, 2);
    repeat (3) @(negedge clk);
    // two stop bits, FIFO filled during the frame
    sel = 2'd3;
    r0 = rd_cnt;
    push(8'h80);
    start_wait("s80", 3);
    fork
      begin
        repeat (6) @(negedge clk);
        push(8'h55);
      end
    join_none
    frame("s80", "00000000111", 2);
    check("s80_reads", rd_cnt - r0, 1);
    start_wait("s55", 4);
    frame("s55", "01010101011", 2);
    repeat (10) @(negedge clk);
    check("s_reads", rd_cnt - r0, 2);
    check("total_reads", rd_cnt, wp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
